// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: streaming ReLU + 2x2 / stride-2 max-pool over a raster float32 pixel stream.
// Consumes WIDTH x HEIGHT pixels per frame and emits the (WIDTH/2) x (HEIGHT/2) pooled map.
// Optional feature macro: RELU_MAXPOOL_RELU_EN
//   defined   -> negative inputs (sign bit set, incl. -0.0) clamp to +0.0; magnitude compare
//   undefined -> no clamp; signed sign-magnitude compare, +0.0 == -0.0
module relu_maxpool_2x2 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = 56,
    parameter int unsigned HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int unsigned COL_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W    = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int unsigned LB_DEPTH = WIDTH / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] linebuf [LB_DEPTH];

    logic                  col_last;
    logic                  row_last;
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] pix_x;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] pooled;

    // max(a, b) on raw float bits; ties return a
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
`ifdef RELU_MAXPOOL_RELU_EN
        // Operands are already clamped non-negative, so magnitude order is value order
        return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
`else
        logic                  sa;
        logic                  sb;
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        sa = a[DATA_WIDTH-1];
        sb = b[DATA_WIDTH-1];
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (ma == '0 && mb == '0) begin
            return a;                       // +0.0 and -0.0 are equal
        end else if (sa != sb) begin
            return sa ? b : a;              // the non-negative operand wins
        end else if (!sa) begin
            return (mb > ma) ? b : a;
        end else begin
            return (mb < ma) ? b : a;       // both negative: smaller magnitude is larger
        end
`endif
    endfunction

    // Pre-process, window position decode and the two compare stages
    always_comb begin
`ifdef RELU_MAXPOOL_RELU_EN
        pix_x = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
        pix_x = data_in;
`endif
        col_last = (col_q == COL_W'(WIDTH - 1));
        row_last = (row_q == ROW_W'(HEIGHT - 1));
        lb_addr  = LB_AW'(col_q >> 1);
        hmax     = fmax(hold_q, pix_x);
        pooled   = fmax(linebuf[lb_addr], hmax);
    end

    // Raster position counters; the frame wraps seamlessly into the next one
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counters, horizontal hold register and registered pooled output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (valid_in) begin
                if (!col_q[0]) begin
                    hold_q <= pix_x;
                end else if (row_q[0]) begin
                    data_out   <= pooled;
                    valid_out  <= 1'b1;
                    frame_done <= row_last && col_last;
                end
            end
        end
    end

    // Line buffer: even rows store the horizontal max, odd rows read it back (never same cycle)
    always_ff @(posedge clk) begin
        if (valid_in && col_q[0] && !row_q[0]) begin
            linebuf[lb_addr] <= hmax;
        end
    end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Bench for relu_maxpool_2x2: a 4x4 and a 56x56 instance, driven one at a time.
// Expected pooled pixels are computed from the stored frame when pixel (odd,odd) is driven,
// pushed with their due cycle, and compared every cycle by the output monitor.
module tb_relu_maxpool_2x2;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic        sel_l = 1'b0;
    logic [31:0] din = '0;

    logic        vin_s, vin_l;
    logic        vo_s, fd_s, vo_l, fd_l;
    logic [31:0] do_s, do_l;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_ev;
    logic [31:0] last_s = '0;
    logic [31:0] last_l = '0;
    logic [31:0] stim;
    logic [31:0] pix [0:55][0:55];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_w = 4;
    int cur_h = 4;
    int m_col = 0;
    int m_row = 0;
    int out_cnt_l = 0;
    int fd_cnt_l = 0;
    int out_at_fd1 = -1;

    assign vin_s = vin & ~sel_l;
    assign vin_l = vin & sel_l;

    relu_maxpool_2x2 #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (vin_s),
        .data_in    (din),
        .valid_out  (vo_s),
        .data_out   (do_s),
        .frame_done (fd_s)
    );

    relu_maxpool_2x2 #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) u_dut_l (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (vin_l),
        .data_in    (din),
        .valid_out  (vo_l),
        .data_out   (do_l),
        .frame_done (fd_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference ordering: sign-magnitude float mapped onto a signed integer line (-0 == +0)
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'({1'b0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] pre(input logic [31:0] x);
`ifdef RELU_MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] pool(input int r, input int c);
        logic [31:0] top;
        logic [31:0] bot;
        top = ref_max(pre(pix[r-1][c-1]), pre(pix[r-1][c]));
        bot = ref_max(pre(pix[r][c-1]), pre(pix[r][c]));
        return ref_max(top, bot);
    endfunction

    function automatic logic [31:0] rand_pix();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h3F80_0000;
            3:       return 32'hBF80_0000;
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)),
                             23'($urandom())};
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 vin = 1'b0;
        end
    endtask

    // Drive one pixel after `gap` idle cycles and update the frame model
    task automatic send(input logic [31:0] d, input int gap);
        exp_t e;
        idle(gap);
        @(posedge clk);
        #1;
        vin = 1'b1;
        din = d;
        pix[m_row][m_col] = d;
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            e.due  = cyc + 1;
            e.data = pool(m_row, m_col);
            e.last = (m_row == cur_h - 1) && (m_col == cur_w - 1);
            exp_q.push_back(e);
        end
        if (m_col == cur_w - 1) begin
            m_col = 0;
            m_row = (m_row == cur_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Output monitor: every cycle compares the selected instance against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            last_s = '0;
            last_l = '0;
        end
        while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
        mon_ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check_eq("valid_out", 32'(sel_l ? vo_l : vo_s), 32'(mon_ev));
        check_eq("idle_inst_valid", 32'(sel_l ? vo_s : vo_l), 32'h0);
        if (mon_ev) begin
            mon_e = exp_q.pop_front();
            check_eq("data_out", sel_l ? do_l : do_s, mon_e.data);
            check_eq("frame_done", 32'(sel_l ? fd_l : fd_s), 32'(mon_e.last));
            if (sel_l) last_l = mon_e.data;
            else       last_s = mon_e.data;
        end else begin
            check_eq("frame_done_idle", 32'(sel_l ? fd_l : fd_s), 32'h0);
            check_eq("data_hold", sel_l ? do_l : do_s, sel_l ? last_l : last_s);
        end
        if (vo_l) out_cnt_l++;
        if (fd_l) begin
            fd_cnt_l++;
            if (fd_cnt_l == 1) out_at_fd1 = out_cnt_l;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid_s", 32'(vo_s), 32'h0);
        check_eq("rst_fd_s", 32'(fd_s), 32'h0);
        check_eq("rst_data_s", do_s, 32'h0);
        check_eq("rst_valid_l", 32'(vo_l), 32'h0);
        check_eq("rst_fd_l", 32'(fd_l), 32'h0);
        check_eq("rst_data_l", do_l, 32'h0);
        rst = 1'b1;
        idle(2);

        // 4x4 frames back to back with valid_in held high
        cur_w = 4;
        cur_h = 4;
        for (int i = 0; i < 16; i++) begin
            stim = rand_pix();
            if (i == 0) stim = 32'h3F80_0000;
            if (i == 1) stim = 32'h4000_0000;
            if (i == 4) stim = 32'h3F00_0000;
            if (i == 5) stim = 32'h3FC0_0000;
            send(stim, 0);
        end
        for (int i = 0; i < 16; i++) send(32'hBF80_0000, 0);
        for (int i = 0; i < 16; i++) begin
            stim = rand_pix();
            if (i == 0) stim = 32'hC000_0000;
            if (i == 1) stim = 32'hBF00_0000;
            if (i == 4) stim = 32'hC040_0000;
            if (i == 5) stim = 32'hBF80_0000;
            send(stim, 0);
        end
        for (int i = 0; i < 16; i++) send(rand_pix(), 0);
        idle(3);

        // Reset mid-frame after 30 pixels, then a full fresh frame
        for (int i = 0; i < 30; i++) send(rand_pix(), int'($urandom_range(0, 2)));
        idle(3);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        idle(2);
        rst = 1'b1;
        idle(2);
        for (int i = 0; i < 16; i++) send(rand_pix(), int'($urandom_range(0, 2)));
        idle(3);

        // Two back-to-back 56x56 frames with random valid gaps
        sel_l = 1'b1;
        cur_w = 56;
        cur_h = 56;
        m_col = 0;
        m_row = 0;
        idle(2);
        for (int i = 0; i < 2 * 56 * 56; i++) send(rand_pix(), int'($urandom_range(0, 5)));
        idle(4);

        check_eq("frames_l", 32'(fd_cnt_l), 32'd2);
        check_eq("outs_frame1_l", 32'(out_at_fd1), 32'd784);
        check_eq("outs_total_l", 32'(out_cnt_l), 32'd1568);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_2x2.md
# relu_maxpool_2x2

Streaming ReLU + 2×2/stride-2 max-pool stage that sits directly downstream of a conv2d feature-map filter. It consumes the filter's single-lane IEEE-754 float32 pixel stream (`data_out`/`valid_out`, raster order, WIDTH×HEIGHT per frame) and emits the pooled (WIDTH/2)×(HEIGHT/2) map in raster order. One instance is used per filter output, with no backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 32: pixel width (float32).
- `WIDTH`, 56: input columns per row; must be even and ≥ 2.
- `HEIGHT`, 56: input rows per frame; must be even and ≥ 2.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `valid_in`  in  1  qualifies `data_in` for one cycle; driven by the filter's `valid_out`.
- `data_in`  in  DATA_WIDTH  float32 pixel.
- `valid_out`  out  1  one-cycle pulse; `data_out` holds a pooled pixel.
- `data_out`  out  DATA_WIDTH  pooled float32 pixel.
- `frame_done`  out  1  one-cycle pulse, coincident with the last pooled pixel of a frame.

## Operation
- Counters:
  - `col` counts 0..WIDTH-1 and `row` counts 0..HEIGHT-1.
  - Both advance only on `valid_in`.
  - `col` wraps to 0 and increments `row`; `row` wraps to 0 after HEIGHT-1 (next frame starts seamlessly).
- Pre-process: x = relu(data_in) when RELU_EN is compiled in (see Configuration).
- Comparator `max(a,b)`, with RELU_EN: operands are non-negative, so it is an unsigned 31-bit magnitude compare. Ties return `a`.
- Horizontal stage (per accepted pixel):
  - Even `col`: register x into `hold`.
  - Odd `col`: hmax = max(hold, x).
- Vertical stage, at odd `col`:
  - Even `row`: write hmax into line buffer entry `col>>1` (depth WIDTH/2, DATA_WIDTH wide, registers or inferred RAM).
  - Odd `row`: `data_out` ← max(linebuf[`col>>1`], hmax) and `valid_out` ← 1.
- `frame_done` ← 1 with the output for `row`=HEIGHT-1, `col`=WIDTH-1.
- `valid_in` gaps of any length are allowed; state holds.
- NaN inputs are not supported; the result is the compare outcome on raw bits.

## Timing
- Reset (asynchronous assert, `rst`=0): `valid_out`=0, `data_out`=0, `frame_done`=0, `col`=0, `row`=0, `hold`=0. Line buffer contents are don't-care because they are always written before being read.
- Reset mid-frame: the partial frame is discarded. The first `valid_in` after release is treated as pixel (0,0).
- Latency: `valid_out` asserts the cycle after the `valid_in` carrying pixel (odd row, odd col).
- `valid_out` and `frame_done` are single-cycle. `data_out` holds its value until the next pooled pixel.
- Throughput: one input per cycle sustained. Output rate is ≤ 1 per 2 input cycles.
- A line-buffer write and read never target the same address in the same cycle, because even and odd rows are exclusive.
- Back-to-back frames: the (0,0) pixel of frame N+1 may arrive in the cycle immediately after the final pixel of frame N. `frame_done` for N still pulses in that cycle.

## Configuration
- Macro `RELU_MAXPOOL_RELU_EN`.
- Defined:
  - Clamp: any input with sign bit 1 (including -0.0) becomes 32'h00000000 before pooling.
  - The comparator is a plain magnitude compare.
- Undefined:
  - No clamp.
  - The comparator is signed sign-magnitude. If signs differ, the positive operand wins. If both are positive, the larger magnitude wins. If both are negative, the smaller magnitude wins.
  - -0.0 and +0.0 compare equal, and `a` is returned.
  - Output may be negative.

## Test plan
- WIDTH=HEIGHT=4; window (0,0),(0,1),(1,0),(1,1) = 1.0 (3F800000), 2.0 (40000000), 0.5 (3F000000), 1.5 (3FC00000). Required: pooled (0,0) = 40000000, with `valid_out` one cycle after pixel (1,1).
- All 16 inputs are -1.0 (BF800000). With the macro: 4 outputs of 00000000 and `frame_done` on the 4th. Without the macro: 4 outputs of BF800000.
- Mixed signs without the macro, window {-2.0 C0000000, -0.5 BF000000, -3.0 C0400000, -1.0 BF800000}. Required: BF000000.
- Random `valid_in` gaps (0–5 idle cycles) over two back-to-back 56×56 frames. Required: exactly 784 `valid_out` per frame, values matching the reference model, and `frame_done` exactly twice.
- `rst` pulsed low after 30 pixels of a frame, then a full 4×4 frame is sent. Required: outputs are all 0 during and after reset until the new frame, then 4 correct outputs. No output uses pre-reset data.
- Sustained `valid_in`=1 every cycle. Required: pooled outputs appear every second cycle during odd rows and are absent during even rows.
